// File: rtl/dmem_pkg.sv
// dmem_pkg: size codes, FSM states and byte-lane mask shared by the data-memory responder
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] SZ_DOUBLE = 2'd3;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
    function automatic logic [7:0] lane_mask(input logic [1:0] size);
        return size == SZ_DOUBLE ? 8'hFF : size == SZ_WORD ? 8'h0F : size == SZ_HALF ? 8'h03 : 8'h01;
    endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: valid/ready request channel with single-cycle response pulse
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    modport master (output req_valid, req_write, req_size, req_addr, req_wdata,
                    input  req_ready, resp_valid, resp_rdata, resp_err);
    modport slave  (input  req_valid, req_write, req_size, req_addr, req_wdata,
                    output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: byte storage with sync clear, 8-lane masked write and 8-byte read at a byte offset
module dmem_byte_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wmask,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);
    logic [7:0] mem_q [2**AW];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**AW; i++) mem_q[i] <= '0;
        end else if (we) begin
            for (int i = 0; i < 8; i++) if (wmask[i]) mem_q[addr + AW'(i)] <= wdata[8*i +: 8];
        end
    end
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) rdata[8*i +: 8] = mem_q[addr + AW'(i)];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency load/store responder over a byte-addressed little-endian memory
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 64,
    parameter int LATENCY    = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d, err_q, err_d;
    logic [1:0]            size_q, size_d;
    logic [63:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic                  idle, go, bad, we;
    logic [2:0]            span;
    logic [7:0]            mask;
    logic [ADDR_WIDTH:0]   end_addr;
    logic [63:0]           rd, rd_m;
    dmem_byte_array #(.AW(ADDR_WIDTH)) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .addr  (addr_d[ADDR_WIDTH-1:0]),
        .wmask (mask),
        .wdata (wdata_d),
        .rdata (rd)
    );
    // With LATENCY==1 the commit edge is also the accept edge, so the live bus request is used in IDLE.
    always_comb begin
        idle     = state_q == IDLE;
        wr_d     = idle ? bus.req_write : wr_q;
        size_d   = idle ? bus.req_size : size_q;
        addr_d   = idle ? bus.req_addr : addr_q;
        wdata_d  = idle ? bus.req_wdata : wdata_q;
        mask     = lane_mask(size_d);
        span     = 3'((4'd1 << size_d) - 4'd1);
        end_addr = {1'b0, addr_d[ADDR_WIDTH-1:0]} + (ADDR_WIDTH+1)'(span);
        bad      = |(addr_d[2:0] & span) | |addr_d[63:ADDR_WIDTH] | end_addr[ADDR_WIDTH];
        go       = idle ? bus.req_valid && LATENCY == 1 : state_q == WAIT && cnt_q == 4'd1;
        state_d  = state_q == RESP ? IDLE : go ? RESP : idle && bus.req_valid ? WAIT : state_q;
        cnt_d    = idle && bus.req_valid ? 4'(LATENCY - 1) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
        rd_m     = '0;
        for (int i = 0; i < 8; i++) rd_m[8*i +: 8] = mask[i] ? rd[8*i +: 8] : 8'h00;
        we       = go && wr_d && !bad;
        rdata_d  = go && !wr_d && !bad ? rd_m : '0;
        err_d    = go && bad;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    assign bus.req_ready  = idle;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
